fifo_uart_tx: RTL

Downstream consumer of the 8-entry synchronous FIFO. It pops one byte at a time over the FIFO's rd/empty/data_out interface and serialises it as an asynchronous UART frame on a single tx line. Frames are start bit, 8 data bits LSB first, optional parity bit and one stop bit. The block decouples byte producers from the slow serial line; the FIFO absorbs bursts.

---
 rtl/fifo_uart_tx.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a synchronous FIFO and sends each one as an
// asynchronous UART frame (start, 8 data bits LSB first, optional parity, stop).
// Every output comes straight from a flop, and tx idles high.
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int unsigned      CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] BAUD_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_REQ = 3'd1,
    RD_CAP = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_e;

  state_e           state_q;
  logic [7:0]       shift_q;
  logic [2:0]       bit_q;
  logic [CNT_W-1:0] baud_q;
  logic             parity_q;
  logic             fifo_rd_q;
  logic             tx_q;
  logic             busy_q;
  logic             tx_done_q;

  logic             baud_last_d;
  logic             parity_d;

  // Parity of one data byte; odd parity is the inverse of the plain XOR.
  function automatic logic frame_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  assign baud_last_d = (baud_q == BAUD_LAST);
  assign parity_d    = frame_parity(fifo_data, PARITY_ODD);

  // Frame sequencer: FIFO handshake, bit timing and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      shift_q   <= 8'h00;
      bit_q     <= 3'd0;
      baud_q    <= '0;
      parity_q  <= 1'b0;
      fifo_rd_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      // Both strobes are single-cycle pulses unless a branch re-asserts them.
      fifo_rd_q <= 1'b0;
      tx_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (enable && !fifo_empty) begin
            state_q   <= RD_REQ;
            fifo_rd_q <= 1'b1;
            busy_q    <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        RD_REQ: begin
          // The FIFO pops at the edge closing this cycle; its data is valid next cycle.
          state_q <= RD_CAP;
        end
        RD_CAP: begin
          shift_q  <= fifo_data;
          parity_q <= parity_d;
          bit_q    <= 3'd0;
          baud_q   <= '0;
          tx_q     <= 1'b0;
          state_q  <= START;
        end
        START: begin
          if (baud_last_d) begin
            baud_q  <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
        DATA: begin
          if (baud_last_d) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              if (PARITY_EN) begin
                tx_q    <= parity_q;
                state_q <= PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= STOP;
              end
            end else begin
              // Next bit is shift_q[1]; drive it now so tx stays registered.
              bit_q   <= bit_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
        PARITY: begin
          if (baud_last_d) begin
            baud_q  <= '0;
            tx_q    <= 1'b1;
            state_q <= STOP;
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
        STOP: begin
          if (baud_last_d) begin
            baud_q    <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            tx_done_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          baud_q  <= '0;
        end
      endcase
    end
  end

  assign fifo_rd = fifo_rd_q;
  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_done = tx_done_q;

endmodule
